divider: RTL and testbench
==========================

# divider

Multi-cycle restoring integer divider for the RV64 integer datapath, executing DIV/DIVU/REM/REMU in one shared unit. It retires one quotient bit per clock by reusing the existing `adder` in subtract mode. Its carry-out serves as the "partial remainder ≥ divisor" decision. The block sits beside the ALU with a valid/ready handshake on both sides, so the pipeline can stall on it.

## Interface
- `InputSize`, 64: operand and result width in bits.

- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands and `is_signed` are valid.
- `in_ready`  out  1: unit idle and able to accept.
- `a`  in  InputSize: dividend.
- `b`  in  InputSize: divisor.
- `is_signed`  in  1: 1 = two's-complement (DIV/REM); 0 = unsigned.
- `out_valid`  out  1: `q`, `r`, `div_by_zero` valid.
- `out_ready`  in  1: consumer takes the result.
- `q`  out  InputSize: quotient.
- `r`  out  InputSize: remainder.
- `div_by_zero`  out  1: `b` was zero for this result.

## Operation
- Operations are accepted only in IDLE. `in_ready` = (state == IDLE). Acceptance occurs on a rising edge with `in_valid && in_ready`. The block latches `a`, `b` and `is_signed`, converts the operands to magnitudes, and records the quotient sign (sign(a) ^ sign(b)) and the remainder sign (sign(a)).
- The state machine has four states:
  - IDLE: moves to CALC on accept.
  - CALC: runs a counter from 0 to InputSize-1 and moves to FIX after the last iteration.
  - FIX: applies sign correction and special cases, then moves to DONE.
  - DONE: holds the result and moves to IDLE on `out_ready`.
- Each CALC iteration works on an (InputSize+1)-bit partial remainder `pr`:
  - Shift: `t = {pr[InputSize-1:0], dividend_msb}`, with the dividend register shifted left.
  - Subtract: `adder` of width InputSize+1 with `sub = 1` computes `t - {1'b0,|b|}`.
  - Decide: if `c_o = 1` (no borrow), `pr` ← difference and the quotient bit is 1. Otherwise `pr` ← `t` and the quotient bit is 0.
- FIX applies the following:
  - Negate `q` if the quotient sign is set and `is_signed`.
  - Negate `r` if the remainder sign is set and `is_signed`.
  - Divide by zero (`b == 0`): `q` = all ones, `r` = `a`, `div_by_zero` = 1.
  - Signed overflow (`a` = most negative, `b` = all ones, `is_signed`): `q` = `a`, `r` = 0.
  - These results take priority over the computed values.
- Results hold stable in DONE while `out_ready` = 0. `in_valid` outside IDLE is ignored, with no queuing.

## Timing
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `q` = 0, `r` = 0, `div_by_zero` = 0, and all internal registers 0.
- Reset mid-operation aborts the operation immediately; the result is discarded.
- Latency: `out_valid` rises InputSize+2 cycles after the accept edge (66 for the default width). This is one accept cycle, InputSize CALC cycles and one FIX cycle.
- `out_valid && out_ready` on edge N gives IDLE with `in_ready` = 1 after edge N. The next accept can happen on edge N+1, so issue throughput is InputSize+3 cycles. There is no same-cycle turnaround.
- `q`, `r` and `div_by_zero` are registered outputs, changing only on the FIX→DONE edge or on reset.

## Configuration
- `DIVIDER_EARLY_OUT_EN`
  - Defined: divide-by-zero and signed overflow are detected on the accept edge. The state jumps to FIX, skipping CALC, so `out_valid` rises 2 cycles after accept.
  - Undefined: every operation runs all InputSize CALC iterations. The special-case values are forced in FIX, so latency is always InputSize+2.
  - Result values are identical either way.

## Structure
- Shared package `divider_pkg` holds:
  - the state typedef (IDLE, CALC, FIX, DONE);
  - the iteration-counter width constant, $clog2(InputSize).
- Sub-module: the existing `adder`, instantiated once with width InputSize+1. No other hierarchy.

## Test plan
- Unsigned divide: `a`=100, `b`=7, `is_signed`=0 → `q`=14, `r`=2, `div_by_zero`=0. `out_valid` exactly 66 cycles after accept.
- Signed divide: `a`=-7, `b`=2 → `q`=0xFFFF_FFFF_FFFF_FFFD (-3), `r`=0xFFFF_FFFF_FFFF_FFFF (-1). Also `a`=7, `b`=-2 → `q`=-3, `r`=1.
- Divide by zero: `a`=5, `b`=0 → `q`=0xFFFF_FFFF_FFFF_FFFF, `r`=5, `div_by_zero`=1. Latency is 2 cycles with `DIVIDER_EARLY_OUT_EN`, 66 without.
- Signed overflow: `a`=0x8000_0000_0000_0000, `b`=-1, `is_signed`=1 → `q`=0x8000_0000_0000_0000, `r`=0. Same operands unsigned → `q`=0, `r`=0x8000_0000_0000_0000.
- Backpressure and ignored input: hold `out_ready`=0 for 5 cycles after `out_valid` → result stable, `in_ready`=0. Pulse `in_valid` with new operands during CALC → no effect on the result.
- Reset mid-operation: assert `rst` 10 cycles into CALC → `out_valid`=0, `q`=`r`=0, `in_ready`=1 after release. A following `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=1 unsigned → `q`=0xFFFF_FFFF_FFFF_FFFF, `r`=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
// DIVIDER_EARLY_OUT_EN (see divider.sv) does not affect anything here.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DefInputSize = 64;
  localparam int CntW         = $clog2(DefInputSize);

  // Iteration-counter width for an arbitrary operand width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Ripple adder/subtractor: s = a + b, or a - b when sub = 1.
// c_o = 1 in subtract mode means no borrow (a >= b, unsigned).
module adder #(
  parameter int Width = 65
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             sub,
  output logic [Width-1:0] s,
  output logic             c_o
);

  logic [Width-1:0] w_b_eff;

  assign w_b_eff  = b ^ {Width{sub}};
  assign {c_o, s} = {1'b0, a} + {1'b0, w_b_eff} + (Width + 1)'(sub);

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Define DIVIDER_EARLY_OUT_EN to skip CALC for divide-by-zero and signed overflow.
module divider
  import divider_pkg::*;
#(
  parameter int InputSize = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [InputSize-1:0] a,
  input  logic [InputSize-1:0] b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [InputSize-1:0] q,
  output logic [InputSize-1:0] r,
  output logic                 div_by_zero
);

  localparam int W  = InputSize;
  localparam int CW = cnt_width(InputSize);
  localparam logic [W-1:0] MostNeg = {1'b1, {(W-1){1'b0}}};

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_dvd;
  logic [W-1:0]    r_quo;
  logic [W-1:0]    r_bmag;
  logic [W-1:0]    r_a;
  logic [W:0]      r_pr;
  logic            r_qneg;
  logic            r_rneg;
  logic            r_bz;
  logic            r_ovf;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_r;
  logic            r_dbz;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic            w_b_zero;
  logic            w_ovf;
  logic [W:0]      w_t;
  logic [W:0]      w_diff;
  logic            w_co;
  logic [W-1:0]    w_q_fix;
  logic [W-1:0]    w_r_fix;
  logic            w_unused;

  // Operand conditioning on the accept cycle.
  assign w_a_neg  = is_signed & a[W-1];
  assign w_b_neg  = is_signed & b[W-1];
  assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
  assign w_b_zero = (b == '0);
  assign w_ovf    = is_signed && (a == MostNeg) && (b == '1);

  // Shift in the next dividend bit, then trial-subtract |b|.
  assign w_t = {r_pr[W-1:0], r_dvd[W-1]};

  adder #(
    .Width (W + 1)
  ) u_adder (
    .a   (w_t),
    .b   ({1'b0, r_bmag}),
    .sub (1'b1),
    .s   (w_diff),
    .c_o (w_co)
  );

  // The kept remainder is always below |b|, so its top bit never reaches w_t.
  assign w_unused = r_pr[W];

  always_comb begin
    w_q_fix = r_qneg ? (~r_quo + 1'b1) : r_quo;
    w_r_fix = r_rneg ? (~r_pr[W-1:0] + 1'b1) : r_pr[W-1:0];
    if (r_bz) begin
      w_q_fix = '1;
      w_r_fix = r_a;
    end else if (r_ovf) begin
      w_q_fix = r_a;
      w_r_fix = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_quo       <= '0;
      r_bmag      <= '0;
      r_a         <= '0;
      r_pr        <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_bz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_dvd      <= w_a_mag;
            r_bmag     <= w_b_mag;
            r_qneg     <= w_a_neg ^ w_b_neg;
            r_rneg     <= w_a_neg;
            r_bz       <= w_b_zero;
            r_ovf      <= w_ovf;
            r_pr       <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
`ifdef DIVIDER_EARLY_OUT_EN
            r_state    <= (w_b_zero || w_ovf) ? FIX : CALC;
`else
            r_state    <= CALC;
`endif
          end
        end
        CALC: begin
          r_dvd <= {r_dvd[W-2:0], 1'b0};
          r_pr  <= w_co ? w_diff : w_t;
          r_quo <= {r_quo[W-2:0], w_co};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) r_state <= FIX;
        end
        FIX: begin
          r_q         <= w_q_fix;
          r_r         <= w_r_fix;
          r_dbz       <= r_bz;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes model results, a monitor pops and compares.
`timescale 1ns/1ps
module tb_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MostNeg = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] AllOnes = '1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  always #5 clk = ~clk;

  divider #(.InputSize(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           issue;
    int           hold;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hold_left = 0;
  bit   active = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: RISC-V DIV/DIVU/REM/REMU semantics with plain arithmetic.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    bit special;
    sa = ma;
    sb = mb;
    e.dbz = 1'b0;
    special = 0;
    if (mb == '0) begin
      e.q = AllOnes; e.r = ma; e.dbz = 1'b1; special = 1;
    end else if (ms && ma == MostNeg && mb == AllOnes) begin
      e.q = ma; e.r = '0; special = 1;
    end else if (ms) begin
      e.q = sa / sb; e.r = sa % sb;
    end else begin
      e.q = ma / mb; e.r = ma % mb;
    end
`ifdef DIVIDER_EARLY_OUT_EN
    e.lat = special ? 2 : W + 2;
`else
    e.lat = W + 2;
`endif
    e.issue = 0;
    e.hold = 0;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s, input int hold);
    exp_t e;
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!in_ready && k < 400);
    if (!in_ready) begin
      check("in_ready_timeout", W'(in_ready), W'(1));
      return;
    end
    a = ia; b = ib; is_signed = s; in_valid = 1'b1;
    e = model(ia, ib, s);
    e.issue = cyc;
    e.hold = hold;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    is_signed = $urandom_range(0, 1);
  endtask

  // Monitor: pops on the first valid cycle, then checks the held result until handshake.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      active = 0;
      out_ready = 1'b0;
    end else if (out_valid) begin
      if (!active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", W'(out_valid), W'(0));
        end else begin
          cur = exp_q.pop_front();
          active = 1;
          hold_left = cur.hold;
          check("latency", W'(cyc - cur.issue), W'(cur.lat));
        end
      end
      if (active) begin
        check("q", q, cur.q);
        check("r", r, cur.r);
        check("div_by_zero", W'(div_by_zero), W'(cur.dbz));
        if (hold_left > 0) check("in_ready_busy", W'(in_ready), W'(0));
      end
      if (hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = 1'b1;
      end
    end else begin
      active = 0;
      out_ready = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int k;

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_q", q, '0);
    check("rst_r", r, '0);
    check("rst_dbz", W'(div_by_zero), W'(0));
    rst = 1'b0;

    issue(64'd100, 64'd7, 1'b0, 0);
    issue(-64'sd7, 64'd2, 1'b1, 0);
    issue(64'd7, -64'sd2, 1'b1, 0);
    issue(64'd5, 64'd0, 1'b1, 0);
    issue(64'd5, 64'd0, 1'b0, 0);
    issue(MostNeg, AllOnes, 1'b1, 0);
    issue(MostNeg, AllOnes, 1'b0, 0);

    // Backpressure plus an in_valid pulse while the unit is busy.
    issue(64'd123456789, 64'd67, 1'b0, 5);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; a = 64'd999; b = 64'd3; is_signed = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;

    // Abort 10 cycles into CALC.
    issue(64'd1000, 64'd3, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_q", q, '0);
    check("abort_r", r, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", W'(in_ready), W'(1));
    issue(AllOnes, 64'd1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = AllOnes;
        2:       rb = W'($urandom_range(1, 15));
        3:       rb = -W'($urandom_range(1, 15));
        default: rb = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       ra = MostNeg;
        1:       ra = W'($urandom_range(0, 1000));
        default: ra = {$urandom, $urandom};
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    k = 0;
    while ((exp_q.size() != 0 || active || out_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
